player_bullet_pool: RTL and testbench
=====================================

PLAYER_BULLET_POOL -- requirements
Module: player_bullet_pool

Interface
REQ-001 Parameter NUM_BULLETS, default 3: number of concurrent player-bullet slots (1..8).
REQ-002 Port clk  input  1  system clock.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port tick  input  1  frame-step enable; state advances only on cycles with tick=1.
REQ-005 Port attack, defend  input  1 each  player fire request / player guarding.
REQ-006 Port xPlayer, yPlayer  input  signed 11 / signed 10  player centre.
REQ-007 Port xEnemy, yEnemy  input  signed 11 / signed 10  enemy centre.
REQ-008 Port enemyDefend, enemyQ  input  1 each  enemy guarding / enemy squatting.
REQ-009 Port x, y  output  NUM_BULLETS x signed 11 / signed 10  per-slot bullet centre.
REQ-010 Port isE  output  NUM_BULLETS  per-slot active flag.
REQ-011 Port hitCnt  output  $clog2(NUM_BULLETS+1)  enemy hits registered on the last tick.
REQ-012 Port blocked  output  1  at least one bullet absorbed by enemy guard on the last tick.
REQ-013 Port busy  output  1  fire cooldown nonzero.

Function
REQ-014 On tick=0 cycles all registers SHALL hold; hitCnt and blocked SHALL be 0.
REQ-015 Per tick, each active slot SHALL compute xn = x + BULLET_STEP_X in 12-bit signed arithmetic; all comparisons SHALL be signed and 12-bit.
REQ-016 Collision: xn + BULLET_X > xEnemy - PLAYER_X and |y - yEnemy| vertical overlap, i.e. NOT (y - BULLET_Y > yEnemy + H or y + BULLET_Y < yEnemy - H), with H = SQUAT_PLAYER_Y if enemyQ else PLAYER_Y.
REQ-017 Collision with enemyDefend=0 SHALL clear the slot and count one hit; with enemyDefend=1 it SHALL clear the slot, count no hit and set blocked.
REQ-018 Without collision, xn > MAP_X - BULLET_X SHALL clear the slot silently; otherwise x SHALL take xn.
REQ-019 Collision SHALL take priority over off-map retirement in the same tick.
REQ-020 Fire SHALL occur on a tick when attack=1, defend=0, cooldown=0 and at least one slot was inactive at the start of the tick.
REQ-021 Fire SHALL claim the lowest-index inactive slot: isE=1, x = xPlayer + PLAYER_X + BULLET_X, y = yPlayer; the new bullet SHALL NOT move or collide on its spawn tick.
REQ-022 A slot retired on a tick SHALL NOT be reused on that same tick.
REQ-023 Fire SHALL load cooldown with FIRE_COOLDOWN; each later tick SHALL decrement it to 0; busy = (cooldown != 0).
REQ-024 hitCnt and blocked SHALL be registered, valid the cycle after the evaluating tick, for exactly one cycle.
REQ-025 All outputs SHALL be driven from registers.

Reset
REQ-026 rst_n low SHALL immediately clear all isE, set all x,y to 0, cooldown to 0, hitCnt 0, blocked 0, busy 0.
REQ-027 Reset asserted mid-flight SHALL discard all bullets and pending hit/blocked pulses.

Structure
REQ-028 BULLET_STEP_X, BULLET_X, BULLET_Y, PLAYER_X, PLAYER_Y, SQUAT_PLAYER_Y, MAP_X, FIRE_COOLDOWN SHALL reside in game_pkg; bench values: 8, 4, 4, 16, 32, 16, 320, 8.
REQ-029 Per-slot motion/collision logic SHALL be one sub-module, player_bullet_slot, instantiated NUM_BULLETS times; allocation, cooldown and hit counting in the top.

Verification
REQ-030 Reset, xPlayer=-200, yPlayer=0, attack for one tick -> slot0 isE=1, x=-180, y=0; next tick x=-172; busy=1 for 8 ticks then 0.
REQ-031 Enemy (0,0), enemyDefend=0, bullet from -180 -> tick 21 xn=-12 collides; next cycle hitCnt=1, isE[0]=0.
REQ-032 Same as REQ-031 with enemyDefend=1 -> blocked=1, hitCnt=0, slot cleared.
REQ-033 yPlayer=30, enemy (0,0), enemyQ=1 -> no collision (26 > 16); bullet retires silently when xn > 316, hitCnt stays 0.
REQ-034 attack held, enemy at y=-300 -> spawns on ticks 0, 8, 16 in slots 0,1,2; tick 24 no spawn (pool full); defend=1 suppresses all spawns.
REQ-035 Two bullets colliding on same tick -> hitCnt=2; rst_n pulse mid-flight -> all isE=0 immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game geometry and timing constants plus signed-coordinate helpers.
package game_pkg;

  typedef logic signed [10:0] xpos_t;
  typedef logic signed [9:0]  ypos_t;
  typedef logic signed [11:0] wide_t;
  typedef logic [3:0]         cd_t;

  localparam wide_t BULLET_STEP_X  = 12'sd8;
  localparam wide_t BULLET_X       = 12'sd4;
  localparam wide_t BULLET_Y       = 12'sd4;
  localparam wide_t PLAYER_X       = 12'sd16;
  localparam wide_t PLAYER_Y       = 12'sd32;
  localparam wide_t SQUAT_PLAYER_Y = 12'sd16;
  localparam wide_t MAP_X          = 12'sd320;
  localparam cd_t   FIRE_COOLDOWN  = 4'd8;

  function automatic wide_t sext_x(input xpos_t v);
    return {v[10], v};
  endfunction

  function automatic wide_t sext_y(input ypos_t v);
    return {{2{v[9]}}, v};
  endfunction

endpackage

// File: rtl/player_bullet_slot.sv
// One player-bullet slot: spawn load, per-tick motion, enemy collision and off-map retirement.
module player_bullet_slot
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic               i_spawn,
  input  logic signed [10:0] i_spawn_x,
  input  logic signed [9:0]  i_spawn_y,
  input  logic signed [10:0] i_x_enemy,
  input  logic signed [9:0]  i_y_enemy,
  input  logic               i_enemy_defend,
  input  logic               i_enemy_q,
  output logic signed [10:0] o_x,
  output logic signed [9:0]  o_y,
  output logic               o_active,
  output logic               o_hit,
  output logic               o_block
);

  logic signed [10:0] r_x;
  logic signed [9:0]  r_y;
  logic               r_active;

  wide_t w_xn;
  wide_t w_y;
  wide_t w_ye;
  wide_t w_h;
  logic  w_coll;
  logic  w_off;

  always_comb begin
    w_xn   = sext_x(r_x) + BULLET_STEP_X;
    w_y    = sext_y(r_y);
    w_ye   = sext_y(i_y_enemy);
    w_h    = i_enemy_q ? SQUAT_PLAYER_Y : PLAYER_Y;
    w_coll = r_active
          && (w_xn + BULLET_X > sext_x(i_x_enemy) - PLAYER_X)
          && !((w_y - BULLET_Y > w_ye + w_h) || (w_y + BULLET_Y < w_ye - w_h));
    // Collision wins over leaving the map on the same tick.
    w_off   = r_active && !w_coll && (w_xn > MAP_X - BULLET_X);
    o_hit   = i_tick && w_coll && !i_enemy_defend;
    o_block = i_tick && w_coll && i_enemy_defend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_active <= 1'b0;
    end else if (i_tick) begin
      if (i_spawn) begin
        r_active <= 1'b1;
        r_x      <= i_spawn_x;
        r_y      <= i_spawn_y;
      end else if (r_active) begin
        if (w_coll || w_off) begin
          r_active <= 1'b0;
        end else begin
          r_x <= 11'(w_xn);
        end
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_active = r_active;

endmodule

// File: rtl/player_bullet_pool.sv
// Player bullet pool: slot allocation, fire cooldown and per-tick hit/blocked accounting.
module player_bullet_pool
  import game_pkg::*;
#(
  parameter int unsigned NUM_BULLETS = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_tick,
  input  logic                                   i_attack,
  input  logic                                   i_defend,
  input  logic signed [10:0]                     i_x_player,
  input  logic signed [9:0]                      i_y_player,
  input  logic signed [10:0]                     i_x_enemy,
  input  logic signed [9:0]                      i_y_enemy,
  input  logic                                   i_enemy_defend,
  input  logic                                   i_enemy_q,
  output logic [NUM_BULLETS-1:0][10:0]           o_x,
  output logic [NUM_BULLETS-1:0][9:0]            o_y,
  output logic [NUM_BULLETS-1:0]                 o_is_e,
  output logic [$clog2(NUM_BULLETS+1)-1:0]       o_hit_cnt,
  output logic                                   o_blocked,
  output logic                                   o_busy
);

  localparam int unsigned CntW = $clog2(NUM_BULLETS + 1);

  logic [NUM_BULLETS-1:0] w_active;
  logic [NUM_BULLETS-1:0] w_hit;
  logic [NUM_BULLETS-1:0] w_block;
  logic [NUM_BULLETS-1:0] w_spawn;
  logic                   w_found;
  logic                   w_fire;
  logic signed [10:0]     w_spawn_x;
  logic [CntW-1:0]        w_hit_sum;
  logic                   w_any_block;
  cd_t                    w_cd_d;

  cd_t                    r_cd;
  logic                   r_busy;
  logic [CntW-1:0]        r_hit_cnt;
  logic                   r_blocked;

  assign w_spawn_x = 11'(sext_x(i_x_player) + PLAYER_X + BULLET_X);

  // A cooldown that reaches zero on this very tick does not hold back the next shot.
  assign w_fire = i_tick && i_attack && !i_defend && (r_cd <= 4'd1) && (|(~w_active));

  always_comb begin
    w_spawn = '0;
    w_found = 1'b0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (!w_found && !w_active[i]) begin
        w_spawn[i] = w_fire;
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_hit_sum   = '0;
    w_any_block = 1'b0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      w_hit_sum   = w_hit_sum + CntW'(w_hit[i]);
      w_any_block = w_any_block | w_block[i];
    end
  end

  always_comb begin
    w_cd_d = r_cd;
    if (w_fire) begin
      w_cd_d = FIRE_COOLDOWN;
    end else if (i_tick && r_cd != 4'd0) begin
      w_cd_d = r_cd - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cd      <= '0;
      r_busy    <= 1'b0;
      r_hit_cnt <= '0;
      r_blocked <= 1'b0;
    end else begin
      r_cd      <= w_cd_d;
      r_busy    <= (w_cd_d != 4'd0);
      r_hit_cnt <= w_hit_sum;
      r_blocked <= w_any_block;
    end
  end

  for (genvar g = 0; g < int'(NUM_BULLETS); g++) begin : g_slot
    player_bullet_slot u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_tick        (i_tick),
      .i_spawn       (w_spawn[g]),
      .i_spawn_x     (w_spawn_x),
      .i_spawn_y     (i_y_player),
      .i_x_enemy     (i_x_enemy),
      .i_y_enemy     (i_y_enemy),
      .i_enemy_defend(i_enemy_defend),
      .i_enemy_q     (i_enemy_q),
      .o_x           (o_x[g]),
      .o_y           (o_y[g]),
      .o_active      (w_active[g]),
      .o_hit         (w_hit[g]),
      .o_block       (w_block[g])
    );
  end

  assign o_is_e    = w_active;
  assign o_hit_cnt = r_hit_cnt;
  assign o_blocked = r_blocked;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_player_bullet_pool.sv
// Self-checking bench for player_bullet_pool: vector table plus scoreboarded corner sequences.
module tb_player_bullet_pool;

  localparam int unsigned N = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tick;
  logic               attack;
  logic               defend;
  logic signed [10:0] x_player;
  logic signed [9:0]  y_player;
  logic signed [10:0] x_enemy;
  logic signed [9:0]  y_enemy;
  logic               enemy_defend;
  logic               enemy_q;
  logic [N-1:0][10:0] x;
  logic [N-1:0][9:0]  y;
  logic [N-1:0]       is_e;
  logic [1:0]         hit_cnt;
  logic               blocked;
  logic               busy;

  always #5 clk = ~clk;

  player_bullet_pool #(.NUM_BULLETS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick        (tick),
    .i_attack      (attack),
    .i_defend      (defend),
    .i_x_player    (x_player),
    .i_y_player    (y_player),
    .i_x_enemy     (x_enemy),
    .i_y_enemy     (y_enemy),
    .i_enemy_defend(enemy_defend),
    .i_enemy_q     (enemy_q),
    .o_x           (x),
    .o_y           (y),
    .o_is_e        (is_e),
    .o_hit_cnt     (hit_cnt),
    .o_blocked     (blocked),
    .o_busy        (busy)
  );

  typedef struct {
    string      nm;
    logic [2:0] is_e;
    int         slot;   // slot whose x/y is checked, -1 for none
    int         xv;
    int         yv;
    int         hit;
    logic       blk;
    logic       busy;
  } exp_t;

  typedef struct {
    logic atk;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input string nm, input logic [2:0] ie, input int slot,
                              input int xv, input int yv, input int hit, input logic blk,
                              input logic bsy);
    exp_t e;
    e.nm = nm; e.is_e = ie; e.slot = slot; e.xv = xv; e.yv = yv;
    e.hit = hit; e.blk = blk; e.busy = bsy;
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check_exp(input exp_t e);
    cmp({e.nm, " isE"}, int'(is_e), int'(e.is_e));
    cmp({e.nm, " hitCnt"}, int'(hit_cnt), e.hit);
    cmp({e.nm, " blocked"}, int'(blocked), int'(e.blk));
    cmp({e.nm, " busy"}, int'(busy), int'(e.busy));
    if (e.slot >= 0) begin
      cmp({e.nm, " x"}, int'($signed(x[e.slot])), e.xv);
      cmp({e.nm, " y"}, int'($signed(y[e.slot])), e.yv);
    end
  endtask

  // Drive one cycle, queue its expectation, compare just after the edge.
  task automatic cyc(input logic tk, input exp_t e);
    tick = tk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_exp(sb.pop_front());
  endtask

  task automatic do_reset();
    tick = 1'b0; attack = 1'b0; defend = 1'b0;
    enemy_defend = 1'b0; enemy_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[23];
  exp_t e;

  initial begin
    rst_n = 1'b0; tick = 1'b0; attack = 1'b0; defend = 1'b0;
    x_player = -11'sd200; y_player = 10'sd0;
    x_enemy = 11'sd0; y_enemy = 10'sd0;
    enemy_defend = 1'b0; enemy_q = 1'b0;

    for (int k = 0; k < 23; k++) begin
      tbl[k].atk = (k == 0);
      tbl[k].e   = mk($sformatf("fly k%0d", k), (k < 21) ? 3'b001 : 3'b000,
                      (k < 21) ? 0 : -1, -180 + 8 * k, 0, (k == 21) ? 1 : 0,
                      1'b0, (k <= 7));
    end

    #1;
    check_exp(mk("reset", 3'b000, 0, 0, 0, 0, 1'b0, 1'b0));

    // Single shot hits an undefended enemy, then the same path against a guard.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      enemy_defend = (p == 1);
      for (int k = 0; k < 23; k++) begin
        e = tbl[k].e;
        if (p == 1) begin
          e.blk = (e.hit == 1);
          e.hit = 0;
          e.nm  = {"guard ", e.nm};
        end
        attack = tbl[k].atk;
        cyc(1'b1, e);
      end
    end

    // Squatting enemy is missed; bullet leaves the map silently. Includes a tick=0 hold.
    do_reset();
    y_player = 10'sd30; enemy_q = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      attack = (k == 0);
      cyc(1'b1, mk($sformatf("miss k%0d", k), (k <= 62) ? 3'b001 : 3'b000,
                   (k <= 62) ? 0 : -1, -180 + 8 * k, 30, 0, 1'b0, (k <= 7)));
      if (k == 3) begin
        attack = 1'b0;
        cyc(1'b0, mk("hold", 3'b001, 0, -156, 30, 0, 1'b0, 1'b1));
      end
    end

    // Held fire fills the pool on ticks 0, 8, 16; tick 24 finds no free slot.
    do_reset();
    y_player = 10'sd0; enemy_q = 1'b0; y_enemy = -10'sd300;
    for (int k = 0; k <= 25; k++) begin
      attack = 1'b1;
      cyc(1'b1, mk($sformatf("fill k%0d", k),
                   (k < 8) ? 3'b001 : (k < 16) ? 3'b011 : 3'b111,
                   (k == 8) ? 1 : (k == 16) ? 2 : (k == 24) ? 0 : -1,
                   (k == 24) ? 12 : -180, 0, 0, 1'b0, (k <= 23)));
    end

    do_reset();
    defend = 1'b1; attack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, mk($sformatf("defend k%0d", k), 3'b000, -1, 0, 0, 0, 1'b0, 1'b0));
    end

    // Two bullets collide on the same tick once the enemy drops into their row.
    do_reset();
    y_enemy = -10'sd300;
    for (int k = 0; k <= 31; k++) begin
      attack  = (k <= 8);
      y_enemy = (k >= 30) ? 10'sd0 : -10'sd300;
      cyc(1'b1, mk($sformatf("double k%0d", k),
                   (k < 8) ? 3'b001 : (k < 30) ? 3'b011 : 3'b000,
                   (k == 29) ? 1 : -1, -12, 0, (k == 30) ? 2 : 0, 1'b0, (k <= 15)));
      if (k == 30) begin
        rst_n = 1'b0;
        #1;
        cmp("reset clears hit pulse", int'(hit_cnt), 0);
        #2;
        rst_n = 1'b1;
      end
    end

    // Reset asserted mid-flight discards the bullet immediately.
    attack = 1'b1;
    cyc(1'b1, mk("refire", 3'b001, 0, -180, 0, 0, 1'b0, 1'b1));
    attack = 1'b0;
    cyc(1'b1, mk("refire t1", 3'b001, 0, -172, 0, 0, 1'b0, 1'b1));
    cyc(1'b1, mk("refire t2", 3'b001, 0, -164, 0, 0, 1'b0, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_exp(mk("reset mid", 3'b000, 0, 0, 0, 0, 1'b0, 1'b0));
    #2;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
